// File: rtl/i3c_target_rx.sv
// I3C target receive path: synchronizes SCL/SDA, decodes START/STOP and clock edges,
// matches the static address, ACKs write transfers and receives T-bit-protected bytes.
module i3c_target_rx (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       enable_i,
  input  logic [6:0] static_addr_i,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_oe_o,
  output logic [7:0] rx_data_o,
  output logic       rx_valid_o,
  output logic       addr_match_o,
  output logic [2:0] state_o,
  output logic       error_o
);

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StAddress = 3'd1,
    StAck     = 3'd2,
    StData    = 3'd3,
    StError   = 3'd4
  } state_e;

  state_e     state_q, state_d;
  logic [3:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       rx_valid_q, rx_valid_d;
  logic       error_q, error_d;
  logic       match_q, match_d;

  logic scl_s1, scl_s2, scl_d;
  logic sda_s1, sda_s2, sda_d;
  logic scl_rise, scl_fall, scl_high, start_det, stop_det;
  logic restart;
  logic [7:0] byte_in;
  logic parity_ok;

  // Synchronizers reset to 1 so a released bus looks idle
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      scl_s1 <= 1'b1;
      scl_s2 <= 1'b1;
      scl_d  <= 1'b1;
      sda_s1 <= 1'b1;
      sda_s2 <= 1'b1;
      sda_d  <= 1'b1;
    end else begin
      scl_s1 <= scl_i;
      scl_s2 <= scl_s1;
      scl_d  <= scl_s2;
      sda_s1 <= sda_i;
      sda_s2 <= sda_s1;
      sda_d  <= sda_s2;
    end
  end

  assign scl_rise  = scl_s2 & ~scl_d;
  assign scl_fall  = ~scl_s2 & scl_d;
  assign scl_high  = scl_s2 & scl_d;
  assign stop_det  = scl_high & sda_s2 & ~sda_d;
  assign start_det = scl_high & ~sda_s2 & sda_d & ~stop_det;
  assign byte_in   = {shift_q[6:0], sda_s2};
  // Odd parity over data and the incoming T-bit
  assign parity_ok = ^{shift_q, sda_s2};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      bit_cnt_q  <= 4'd0;
      shift_q    <= 8'h00;
      rx_data_q  <= 8'h00;
      rx_valid_q <= 1'b0;
      error_q    <= 1'b0;
      match_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      error_q    <= error_d;
      match_q    <= match_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    error_d    = 1'b0;
    match_d    = match_q;
    restart    = 1'b0;
    if (stop_det) begin
      state_d = StIdle;
    end else if (start_det) begin
      // A disabled target drops out at the next START instead of re-addressing
      state_d = enable_i ? StAddress : StIdle;
      restart = 1'b1;
    end else begin
      unique case (state_q)
        StIdle: ;
        StAddress: begin
          if (scl_rise) begin
            shift_d   = byte_in;
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd7) begin
              if (byte_in[7:1] == static_addr_i && !byte_in[0]) begin
                state_d = StAck;
                match_d = 1'b1;
              end else begin
                state_d = StIdle;
              end
            end
          end
        end
        // Count 0: wait for fall; 1: driving, wait for rise; 2: driving, wait for fall
        StAck: begin
          if (scl_fall && bit_cnt_q == 4'd0) begin
            bit_cnt_d = 4'd1;
          end else if (scl_rise && bit_cnt_q == 4'd1) begin
            bit_cnt_d = 4'd2;
          end else if (scl_fall && bit_cnt_q == 4'd2) begin
            state_d = StData;
          end
        end
        StData: begin
          if (scl_rise) begin
            if (bit_cnt_q == 4'd8) begin
              if (parity_ok) begin
                rx_data_d  = shift_q;
                rx_valid_d = 1'b1;
                restart    = 1'b1;
              end else begin
                error_d = 1'b1;
                state_d = StError;
              end
            end else begin
              shift_d   = byte_in;
              bit_cnt_d = bit_cnt_q + 4'd1;
            end
          end
        end
        StError: ;
        default: state_d = StIdle;
      endcase
    end
    if (restart || stop_det || state_d != state_q) begin
      bit_cnt_d = 4'd0;
      shift_d   = 8'h00;
    end
    if (state_d == StIdle || state_d == StAddress) begin
      match_d = 1'b0;
    end
  end

  always_comb begin
    sda_oe_o     = (state_q == StAck) && (bit_cnt_q != 4'd0);
    state_o      = state_q;
    rx_data_o    = rx_data_q;
    rx_valid_o   = rx_valid_q;
    error_o      = error_q;
    addr_match_o = match_q;
  end

endmodule
